// File: rtl/mem_arb_pkg.sv
// Shared types for the CPU/DMA memory arbiter: grant selector, last-cycle tag, wait counter width.
package mem_arb_pkg;

    localparam int WAIT_W = 4;

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_CPU,
        GNT_DMA
    } gnt_t;

    typedef enum logic [1:0] {
        LAST_NONE,
        LAST_CPU_RD,
        LAST_DMA_RD
    } last_t;

endpackage

// File: rtl/mem_arb_starve.sv
// Saturating DMA starvation counter; at_max forces the next DMA grant over the CPU.
// One-cycle update, clear has priority over increment.
module mem_arb_starve
    import mem_arb_pkg::*;
#(
    parameter int MAX_WAIT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc,
    input  logic clr,
    output logic at_max
);

    logic [WAIT_W-1:0] cnt_q;
    logic [WAIT_W-1:0] cnt_d;

    assign at_max = (cnt_q == WAIT_W'(MAX_WAIT));

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && !at_max) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// CPU/DMA arbiter for one synchronous memory: CPU fixed priority, DMA forced after MAX_WAIT refusals.
// Combinational grant/stall, read data one cycle after grant; MEM_ARB_STATS_EN adds stall/DMA counters.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW       = 16,
    parameter int DW       = 16,
    parameter int MAX_WAIT = 4
) (
    input  logic          clk,
    input  logic          RST_bar,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_stall,
    input  logic          dma_req,
    input  logic          dma_we,
    input  logic [AW-1:0] dma_addr,
    input  logic [DW-1:0] dma_wdata,
    output logic          dma_gnt,
    output logic [DW-1:0] dma_rdata,
    output logic          dma_rvalid,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_we,
`ifdef MEM_ARB_STATS_EN
    output logic [15:0]   stall_count,
    output logic [15:0]   dma_count,
`endif
    input  logic [DW-1:0] mem_rdata
);

    gnt_t          gnt;
    last_t         last_q, last_d;
    logic          at_max;
    logic [DW-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DW-1:0] dma_rdata_q, dma_rdata_d;

    // Reset low suppresses every grant so nothing reaches the memory port.
    always_comb begin
        gnt = GNT_NONE;
        if (RST_bar) begin
            if (dma_req && (!cpu_req || at_max)) begin
                gnt = GNT_DMA;
            end else if (cpu_req) begin
                gnt = GNT_CPU;
            end
        end
    end

    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_we    = 1'b0;
        case (gnt)
            GNT_CPU: begin
                mem_addr  = cpu_addr;
                mem_wdata = cpu_wdata;
                mem_we    = cpu_we;
            end
            GNT_DMA: begin
                mem_addr  = dma_addr;
                mem_wdata = dma_wdata;
                mem_we    = dma_we;
            end
            default: ;
        endcase
    end

    assign dma_gnt   = (gnt == GNT_DMA);
    assign cpu_stall = cpu_req && dma_gnt;

    mem_arb_starve #(
        .MAX_WAIT (MAX_WAIT)
    ) u_starve (
        .clk    (clk),
        .rst_n  (RST_bar),
        .inc    (dma_req && !dma_gnt),
        .clr    (dma_gnt || !dma_req),
        .at_max (at_max)
    );

    // Read data is bypassed from memory in the data cycle and held afterwards.
    always_comb begin
        case (gnt)
            GNT_CPU: last_d = cpu_we ? LAST_NONE : LAST_CPU_RD;
            GNT_DMA: last_d = dma_we ? LAST_NONE : LAST_DMA_RD;
            default: last_d = LAST_NONE;
        endcase
        cpu_rdata   = (last_q == LAST_CPU_RD) ? mem_rdata : cpu_rdata_q;
        dma_rdata   = (last_q == LAST_DMA_RD) ? mem_rdata : dma_rdata_q;
        dma_rvalid  = (last_q == LAST_DMA_RD);
        cpu_rdata_d = cpu_rdata;
        dma_rdata_d = dma_rdata;
    end

    always_ff @(posedge clk or negedge RST_bar) begin
        if (!RST_bar) begin
            last_q      <= LAST_NONE;
            cpu_rdata_q <= '0;
            dma_rdata_q <= '0;
        end else begin
            last_q      <= last_d;
            cpu_rdata_q <= cpu_rdata_d;
            dma_rdata_q <= dma_rdata_d;
        end
    end

`ifdef MEM_ARB_STATS_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic [15:0] dma_cnt_q, dma_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        dma_cnt_d   = dma_cnt_q;
        if (cpu_stall && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
        if (dma_gnt && (dma_cnt_q != 16'hFFFF)) begin
            dma_cnt_d = dma_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge RST_bar) begin
        if (!RST_bar) begin
            stall_cnt_q <= '0;
            dma_cnt_q   <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            dma_cnt_q   <= dma_cnt_d;
        end
    end

    assign stall_count = stall_cnt_q;
    assign dma_count   = dma_cnt_q;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed table-driven bench for mem_arbiter with a behavioural 1-cycle synchronous memory.
module tb_mem_arbiter;

    localparam bit H = 1'b1;
    localparam bit L = 1'b0;

    logic        clk = 1'b0;
    logic        RST_bar;
    logic        cpu_req, cpu_we, dma_req, dma_we;
    logic [15:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;
    logic [15:0] cpu_rdata, dma_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        cpu_stall, dma_gnt, dma_rvalid, mem_we;
`ifdef MEM_ARB_STATS_EN
    logic [15:0] stall_count, dma_count;
`endif

    logic        ld_en;
    logic [11:0] ld_addr;
    logic [15:0] ld_dat;
    logic [15:0] mem [4096];

    int total = 0;
    int bad   = 0;

    typedef struct {
        bit        creq, cwe;
        bit [15:0] caddr, cwd;
        bit        dreq, dwe;
        bit [15:0] daddr, dwd;
        bit        e_stall, e_gnt, e_mwe;
        bit [15:0] e_maddr, e_mwd;
        bit        e_dvld;
        bit [15:0] e_crd, e_drd;
    } vec_t;

    vec_t vecs [28];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ld_en) begin
            mem[ld_addr] <= ld_dat;
        end else if (mem_we) begin
            mem[mem_addr[11:0]] <= mem_wdata;
        end
        mem_rdata <= mem[mem_addr[11:0]];
    end

    mem_arbiter #(.AW(16), .DW(16), .MAX_WAIT(4)) dut (
        .clk        (clk),
        .RST_bar    (RST_bar),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_rdata  (cpu_rdata),
        .cpu_stall  (cpu_stall),
        .dma_req    (dma_req),
        .dma_we     (dma_we),
        .dma_addr   (dma_addr),
        .dma_wdata  (dma_wdata),
        .dma_gnt    (dma_gnt),
        .dma_rdata  (dma_rdata),
        .dma_rvalid (dma_rvalid),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_we     (mem_we),
`ifdef MEM_ARB_STATS_EN
        .stall_count(stall_count),
        .dma_count  (dma_count),
`endif
        .mem_rdata  (mem_rdata)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic load(input logic [11:0] a, input logic [15:0] d);
        ld_en   = 1'b1;
        ld_addr = a;
        ld_dat  = d;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input vec_t v);
        cpu_req   = v.creq;
        cpu_we    = v.cwe;
        cpu_addr  = v.caddr;
        cpu_wdata = v.cwd;
        dma_req   = v.dreq;
        dma_we    = v.dwe;
        dma_addr  = v.daddr;
        dma_wdata = v.dwd;
    endtask

    initial begin
        // cpu fields | dma fields | stall gnt mwe maddr mwd dvld crd drd
        vecs[0]  = '{H,L,16'h0010,16'h0, H,L,16'h0100,16'h0, L,L,L,16'h0010,16'h0, L,16'h0000,16'h0000};
        vecs[1]  = '{H,L,16'h0010,16'h0, H,L,16'h0100,16'h0, L,L,L,16'h0010,16'h0, L,16'hBEEF,16'h0000};
        vecs[2]  = vecs[1];
        vecs[3]  = vecs[1];
        vecs[4]  = '{H,L,16'h0010,16'h0, H,L,16'h0100,16'h0, H,H,L,16'h0100,16'h0, L,16'hBEEF,16'h0000};
        vecs[5]  = '{H,L,16'h0010,16'h0, H,L,16'h0101,16'h0, L,L,L,16'h0010,16'h0, H,16'hBEEF,16'hA000};
        vecs[6]  = '{H,L,16'h0010,16'h0, H,L,16'h0101,16'h0, L,L,L,16'h0010,16'h0, L,16'hBEEF,16'hA000};
        vecs[7]  = vecs[6];
        vecs[8]  = vecs[6];
        vecs[9]  = '{H,L,16'h0010,16'h0, H,L,16'h0101,16'h0, H,H,L,16'h0101,16'h0, L,16'hBEEF,16'hA000};
        vecs[10] = '{L,L,16'h0000,16'h0, H,L,16'h0100,16'h0, L,H,L,16'h0100,16'h0, H,16'hBEEF,16'hA001};
        vecs[11] = '{L,L,16'h0000,16'h0, H,L,16'h0101,16'h0, L,H,L,16'h0101,16'h0, H,16'hBEEF,16'hA000};
        vecs[12] = '{L,L,16'h0000,16'h0, H,L,16'h0102,16'h0, L,H,L,16'h0102,16'h0, H,16'hBEEF,16'hA001};
        vecs[13] = '{L,L,16'h0000,16'h0, H,L,16'h0103,16'h0, L,H,L,16'h0103,16'h0, H,16'hBEEF,16'hA002};
        vecs[14] = '{L,L,16'h0000,16'h0, L,L,16'h0000,16'h0, L,L,L,16'h0000,16'h0, H,16'hBEEF,16'hA003};
        vecs[15] = '{L,L,16'h0000,16'h0, L,L,16'h0000,16'h0, L,L,L,16'h0000,16'h0, L,16'hBEEF,16'hA003};
        vecs[16] = '{H,L,16'h0010,16'h0, H,L,16'h0102,16'h0, L,L,L,16'h0010,16'h0, L,16'hBEEF,16'hA003};
        vecs[17] = vecs[16];
        vecs[18] = vecs[16];
        vecs[19] = '{H,L,16'h0010,16'h0, L,L,16'h0102,16'h0, L,L,L,16'h0010,16'h0, L,16'hBEEF,16'hA003};
        vecs[20] = vecs[16];
        vecs[21] = vecs[16];
        vecs[22] = vecs[16];
        vecs[23] = vecs[16];
        vecs[24] = '{H,H,16'h0020,16'h1234, H,L,16'h0102,16'h0, H,H,L,16'h0102,16'h0, L,16'hBEEF,16'hA003};
        vecs[25] = '{H,H,16'h0020,16'h1234, L,L,16'h0000,16'h0, L,L,H,16'h0020,16'h1234, H,16'hBEEF,16'hA002};
        vecs[26] = '{H,L,16'h0020,16'h0, L,L,16'h0000,16'h0, L,L,L,16'h0020,16'h0, L,16'hBEEF,16'hA002};
        vecs[27] = '{L,L,16'h0000,16'h0, L,L,16'h0000,16'h0, L,L,L,16'h0000,16'h0, L,16'h1234,16'hA002};

        RST_bar = 1'b0;
        ld_en   = 1'b0;
        ld_addr = '0;
        ld_dat  = '0;
        drive(vecs[0]);
        cpu_we = 1'b1;
        @(posedge clk);
        #1;
        load(12'h010, 16'hBEEF);
        load(12'h100, 16'hA000);
        load(12'h101, 16'hA001);
        load(12'h102, 16'hA002);
        load(12'h103, 16'hA003);
        ld_en = 1'b0;

        // Both requesting (CPU write) while reset is held low.
        @(negedge clk);
        chk("rst.mem_we", 32'(mem_we), 32'd0);
        chk("rst.cpu_stall", 32'(cpu_stall), 32'd0);
        chk("rst.dma_gnt", 32'(dma_gnt), 32'd0);
        chk("rst.dma_rvalid", 32'(dma_rvalid), 32'd0);
        chk("rst.cpu_rdata", 32'(cpu_rdata), 32'd0);
        @(posedge clk);
        #1;

        for (int i = 0; i < 28; i++) begin
            drive(vecs[i]);
            RST_bar = 1'b1;
            @(negedge clk);
            chk($sformatf("r%0d.stall", i), 32'(cpu_stall), 32'(vecs[i].e_stall));
            chk($sformatf("r%0d.gnt", i), 32'(dma_gnt), 32'(vecs[i].e_gnt));
            chk($sformatf("r%0d.mem_we", i), 32'(mem_we), 32'(vecs[i].e_mwe));
            chk($sformatf("r%0d.mem_addr", i), 32'(mem_addr), 32'(vecs[i].e_maddr));
            chk($sformatf("r%0d.mem_wdata", i), 32'(mem_wdata), 32'(vecs[i].e_mwd));
            chk($sformatf("r%0d.rvalid", i), 32'(dma_rvalid), 32'(vecs[i].e_dvld));
            chk($sformatf("r%0d.cpu_rdata", i), 32'(cpu_rdata), 32'(vecs[i].e_crd));
            chk($sformatf("r%0d.dma_rdata", i), 32'(dma_rdata), 32'(vecs[i].e_drd));
            @(posedge clk);
            #1;
        end

        chk("mem_0020", 32'(mem[12'h020]), 32'h1234);
`ifdef MEM_ARB_STATS_EN
        chk("stall_count", 32'(stall_count), 32'd3);
        chk("dma_count", 32'(dma_count), 32'd7);
`endif

        // DMA read granted, then reset pulsed before the edge ending the data cycle.
        cpu_req  = 1'b0;
        dma_req  = 1'b1;
        dma_we   = 1'b0;
        dma_addr = 16'h0103;
        @(negedge clk);
        chk("mid.gnt", 32'(dma_gnt), 32'd1);
        #1;
        RST_bar = 1'b0;
        dma_req = 1'b0;
        #1;
        chk("mid.gnt_in_rst", 32'(dma_gnt), 32'd0);
        #1;
        RST_bar = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("mid.rvalid", 32'(dma_rvalid), 32'd0);
        chk("mid.dma_rdata", 32'(dma_rdata), 32'd0);
        chk("mid.cpu_rdata", 32'(cpu_rdata), 32'd0);
        @(posedge clk);
        #1;

        // Cleared counter: contention again yields C,C,C,C,D twice.
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        cpu_addr = 16'h0010;
        dma_req  = 1'b1;
        dma_addr = 16'h0100;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk($sformatf("post.gnt%0d", k), 32'(dma_gnt), (k % 5 == 4) ? 32'd1 : 32'd0);
            chk($sformatf("post.stall%0d", k), 32'(cpu_stall), (k % 5 == 4) ? 32'd1 : 32'd0);
            @(posedge clk);
            #1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter sharing the single synchronous memory between the CPU fetch/execute path and a DMA requester (serial/storage block-copy engine). The CPU has fixed priority; a starvation counter forces a DMA grant after a bounded wait. The CPU sees a combinational stall that holds its T-state. Sits between the CPU's address register / memory strobes and the memory array.

## Interface
Parameters:
- `AW`, 16: address width.
- `DW`, 16: data width.
- `MAX_WAIT`, 4: cycles DMA may be refused before a forced grant. Legal range 1..15.

Ports:
- `clk` in 1: clock; all state changes on posedge.
- `RST_bar` in 1: reset, asynchronous, active-low.
- `cpu_req` in 1: CPU wants a memory cycle this clock.
- `cpu_we` in 1: CPU write (1) / read (0).
- `cpu_addr` in AW: CPU address.
- `cpu_wdata` in DW: CPU write data.
- `cpu_rdata` out DW: CPU read data, valid the cycle after the grant.
- `cpu_stall` out 1: CPU request refused this cycle; CPU holds T-state and request.
- `dma_req` in 1: DMA request valid.
- `dma_we` in 1: DMA write / read.
- `dma_addr` in AW: DMA address.
- `dma_wdata` in DW: DMA write data.
- `dma_gnt` out 1: DMA request accepted on this edge.
- `dma_rdata` out DW: DMA read data.
- `dma_rvalid` out 1: one-cycle pulse, `dma_rdata` valid (reads only).
- `mem_addr` out AW, `mem_wdata` out DW, `mem_we` out 1: memory port.
- `mem_rdata` in DW: memory read data, 1-cycle synchronous latency.

## Operation
- Grant is combinational each cycle:
  - DMA wins if `dma_req && (!cpu_req || wait_cnt == MAX_WAIT)`.
  - Otherwise CPU wins if `cpu_req`.
  - Otherwise no grant.
- Memory port is a mux of the granted requester's addr/wdata/we. With no grant: `mem_we` = 0, `mem_addr`/`mem_wdata` = 0.
- `cpu_stall` = `cpu_req && DMA granted`.
- `dma_gnt` = DMA granted. DMA treats it as a ready: it advances to the next request on that edge. Back-to-back DMA grants are allowed.
- `wait_cnt` (4-bit):
  - Increments on each edge where `dma_req && !dma_gnt`.
  - Clears on a DMA grant or when `dma_req` is low.
  - Saturates at MAX_WAIT.
- `last` register states: NONE, CPU_RD, DMA_RD, loaded each edge from the current grant (writes load NONE).
  - `cpu_rdata` is `mem_rdata` when `last` = CPU_RD, else holds its previous value.
  - `dma_rdata` is likewise `mem_rdata` when `last` = DMA_RD, else holds.
  - `dma_rvalid` = (`last` = DMA_RD).
- Read data holders are registered. `cpu_rdata`/`dma_rdata` are captured at the edge ending the data cycle and also bypassed combinationally during it.

## Timing
- Reset (`RST_bar` low, async): `last` = NONE, `wait_cnt` = 0, read-data holders = 0. While low, all grants are forced off: `mem_we` = 0, `cpu_stall` = 0, `dma_gnt` = 0, `dma_rvalid` = 0.
- Read latency: grant in cycle N gives data and `dma_rvalid` in cycle N+1. Writes complete at the edge ending cycle N.
- Simultaneous requests: CPU gets cycles N..N+MAX_WAIT-1, DMA is forced at cycle N+MAX_WAIT, then the CPU wins again with the counter cleared.
- Reset asserted mid-read: the pending `dma_rvalid` is dropped; the DMA must reissue.
- `dma_req` dropped before grant: counter clears, no grant, no side effect.
- A CPU write stalled by a forced DMA grant is performed the next cycle unchanged.

## Configuration
- `MEM_ARB_STATS_EN` defined: adds outputs `stall_count` (16-bit) and `dma_count` (16-bit).
  - `stall_count` increments on each cycle with `cpu_stall`.
  - `dma_count` increments on each DMA grant.
  - Both saturate at 16'hFFFF and reset to 0.
- Undefined: those ports and counters do not exist. Arbitration behaviour is identical either way.

## Structure
- Shared package `mem_arb_pkg`:
  - enum `gnt_t` {GNT_NONE, GNT_CPU, GNT_DMA}
  - enum `last_t` {LAST_NONE, LAST_CPU_RD, LAST_DMA_RD}
  - constant `WAIT_W` = 4
- One sub-module, `mem_arb_starve`: the saturating wait counter with `inc`/`clr`/`at_max`, instantiated once.

## Test plan
- Reset: drive `cpu_req`=1 and `dma_req`=1 with `RST_bar` low -> `mem_we`=0, `cpu_stall`=0, `dma_gnt`=0. Release reset -> CPU granted first cycle.
- CPU-only read: preload mem[0x0010]=0xBEEF, `cpu_req` read 0x0010 -> `cpu_stall`=0, `cpu_rdata`=0xBEEF next cycle.
- Contention, MAX_WAIT=4: both request continuously -> grant pattern C,C,C,C,D repeating. `cpu_stall` high exactly every 5th cycle.
- DMA burst: `dma_req` held for reads 0x0100..0x0103 with CPU idle -> four consecutive `dma_gnt`, then `dma_rvalid` on the following four cycles with matching data.
- Stalled CPU write: CPU write 0x1234 to 0x0020 coincides with a forced DMA grant -> write lands one cycle later, mem[0x0020]=0x1234. With `MEM_ARB_STATS_EN`, `stall_count`=1.
- Reset mid-read: DMA read granted, `RST_bar` pulsed low before the next edge -> no `dma_rvalid`, `wait_cnt`=0.
